// File: rtl/pio_input_debounced_if.sv
// ============================================================================
// Module      : pio_input_debounced_if
// Description : Avalon-MM slave bus bundle for the debounced input PIO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pio_input_debounced_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

`default_nettype wire

// File: rtl/pio_input_debounced.sv
// ============================================================================
// Module      : pio_input_debounced
// Description : Avalon-MM input PIO with per-channel synchroniser, debouncer,
//               edge capture and masked level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_input_debounced #(
  parameter int                WIDTH           = 4,
  parameter int                DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0]  RISE_EN_RESET   = '0,
  parameter logic [WIDTH-1:0]  FALL_EN_RESET   = '1
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic [WIDTH-1:0] in_port,
  pio_input_debounced_if.slave  bus
);

  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_capture;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [31:0]      r_readdata;
  logic [31:0]      w_rd_mux;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [c_CNT_W-1:0] r_cnt;
      logic               r_bit;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
          r_bit <= 1'b0;
        end else if (r_sync2[i] == r_bit) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
          r_bit <= r_sync2[i];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end

      assign w_stable[i] = r_bit;
    end
  endgenerate

  generate
    if (WIDTH < 32) begin : g_unused_wd
      logic w_unused_wd;
      assign w_unused_wd = &{1'b0, bus.writedata[31:WIDTH]};
    end
  endgenerate

  assign w_wr  = bus.chipselect & ~bus.write_n;
  assign w_ev  = (w_stable & ~r_stable_d & r_rise_en) |
                 (~w_stable & r_stable_d & r_fall_en);
  assign w_clr = (w_wr && bus.address == 3'd3) ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d     <= '0;
      r_irq_mask     <= '0;
      r_edge_capture <= '0;
      r_rise_en      <= RISE_EN_RESET;
      r_fall_en      <= FALL_EN_RESET;
    end else begin
      r_stable_d     <= w_stable;
      // A new event wins over a same-cycle clear so no edge is ever lost.
      r_edge_capture <= (r_edge_capture & ~w_clr) | w_ev;
      if (w_wr) begin
        case (bus.address)
          3'd2:    r_irq_mask <= bus.writedata[WIDTH-1:0];
          3'd4:    r_rise_en  <= bus.writedata[WIDTH-1:0];
          3'd5:    r_fall_en  <= bus.writedata[WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      3'd0:    w_rd_mux[WIDTH-1:0] = w_stable;
      3'd1:    w_rd_mux[WIDTH-1:0] = r_sync2;
      3'd2:    w_rd_mux[WIDTH-1:0] = r_irq_mask;
      3'd3:    w_rd_mux[WIDTH-1:0] = r_edge_capture;
      3'd4:    w_rd_mux[WIDTH-1:0] = r_rise_en;
      3'd5:    w_rd_mux[WIDTH-1:0] = r_fall_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_edge_capture & r_irq_mask);

endmodule

`default_nettype wire

// File: tb/tb_pio_input_debounced.sv
// ============================================================================
// Module      : tb_pio_input_debounced
// Description : Self-checking bench for pio_input_debounced (WIDTH=4, DEBOUNCE=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pio_input_debounced;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_port;
  int         n_chk = 0;
  int         n_err = 0;

  pio_input_debounced_if bus ();

  pio_input_debounced #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DEB),
    .RISE_EN_RESET   (4'h0),
    .FALL_EN_RESET   (4'hF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a pin delay line, a sliding window of the last DEB
  // synchronised samples, and the register file as plain variables.
  bit [3:0]  m_pin_q[$];
  bit [3:0]  m_hist[$];
  bit [3:0]  m_stable, m_stable_d, m_mask, m_ec, m_rise, m_fall;
  bit [31:0] m_rd;

  always @(posedge clk or negedge reset_n) begin : model
    bit [3:0]  s2, ev, clr, nxt;
    bit [31:0] rd;
    bit        all_diff;
    if (!reset_n) begin
      m_pin_q = {4'h0, 4'h0};
      m_hist.delete();
      m_stable = 0; m_stable_d = 0; m_mask = 0; m_ec = 0;
      m_rise = 4'h0; m_fall = 4'hF; m_rd = 0;
    end else begin
      s2 = m_pin_q.pop_front();
      m_pin_q.push_back(in_port);
      rd = 0;
      case (bus.address)
        3'd0: rd[3:0] = m_stable;
        3'd1: rd[3:0] = s2;
        3'd2: rd[3:0] = m_mask;
        3'd3: rd[3:0] = m_ec;
        3'd4: rd[3:0] = m_rise;
        3'd5: rd[3:0] = m_fall;
        default: rd = 0;
      endcase
      ev = (m_stable & ~m_stable_d & m_rise) | (~m_stable & m_stable_d & m_fall);
      m_hist.push_back(s2);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      nxt = m_stable;
      if (m_hist.size() == DEB) begin
        for (int i = 0; i < 4; i++) begin
          all_diff = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) nxt[i] = ~m_stable[i];
        end
      end
      clr = 0;
      if (bus.chipselect && !bus.write_n) begin
        case (bus.address)
          3'd2: m_mask = bus.writedata[3:0];
          3'd3: clr    = bus.writedata[3:0];
          3'd4: m_rise = bus.writedata[3:0];
          3'd5: m_fall = bus.writedata[3:0];
          default: ;
        endcase
      end
      m_ec       = (m_ec & ~clr) | ev;
      m_stable_d = m_stable;
      m_stable   = nxt;
      m_rd       = rd;
    end
  end

  function automatic bit m_irq();
    return |(m_ec & m_mask);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input bit [2:0] a, input bit [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_port = 4'h0;
    bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.readdata !== 32'h0) begin
      n_err++; $display("FAIL reset_readdata: got %h want 00000000", bus.readdata);
    end
    n_chk++;
    if (bus.irq !== 1'b0) begin
      n_err++; $display("FAIL reset_irq: got %b want 0", bus.irq);
    end
    reset_n = 1'b1;
    bus.address = 3'd5; tick();
    n_chk++;
    if (bus.readdata !== 32'hF) begin
      n_err++; $display("FAIL reset_fall_en: got %h want 0000000f", bus.readdata);
    end
    bus.address = 3'd4; tick();
    n_chk++;
    if (bus.readdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rise_en: got %h want 00000000", bus.readdata);
    end
  endtask

  task automatic test_glitch();
    in_port = 4'hF; bus.address = 3'd0;
    repeat (10) begin
      tick(); n_chk++;
      if (bus.readdata !== m_rd || bus.irq !== m_irq()) begin
        n_err++; $display("FAIL glitch_settle: rd=%h irq=%b want rd=%h irq=%b", bus.readdata, bus.irq, m_rd, m_irq());
      end
    end
    bus_write(3'd3, 32'hF);
    bus.address = 3'd0;
    in_port[0] = 1'b0;
    repeat (3) tick();
    in_port[0] = 1'b1;
    repeat (8) tick();
    n_chk++;
    if (bus.readdata !== 32'hF) begin
      n_err++; $display("FAIL glitch_data: got %h want 0000000f", bus.readdata);
    end
    bus.address = 3'd3; tick(); n_chk++;
    if (bus.readdata !== 32'h0) begin
      n_err++; $display("FAIL glitch_ec: got %h want 00000000", bus.readdata);
    end
    bus.address = 3'd0;
    in_port[0] = 1'b0;
    repeat (6) tick();
    n_chk++;
    if (bus.readdata !== 32'hF) begin
      n_err++; $display("FAIL fall_early: got %h want 0000000f", bus.readdata);
    end
    tick(); n_chk++;
    if (bus.readdata !== 32'hE) begin
      n_err++; $display("FAIL fall_at_6: got %h want 0000000e", bus.readdata);
    end
    bus.address = 3'd3; tick(); n_chk++;
    if (bus.readdata !== 32'h1 || bus.readdata !== m_rd) begin
      n_err++; $display("FAIL fall_ec: got %h want 00000001 (model %h)", bus.readdata, m_rd);
    end
  endtask

  task automatic test_irq();
    bus_write(3'd2, 32'h1);
    bus_write(3'd3, 32'hF);
    in_port[0] = 1'b1;
    repeat (8) tick();
    bus.address = 3'd3;
    in_port[0] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick(); n_chk++;
      if (bus.irq !== m_irq() || bus.readdata !== m_rd || (c == 6 && bus.irq !== 1'b0) || (c == 7 && bus.irq !== 1'b1)) begin
        n_err++; $display("FAIL irq_rise c=%0d: irq=%b rd=%h want irq=%b rd=%h", c, bus.irq, bus.readdata, m_irq(), m_rd);
      end
    end
    bus_write(3'd3, 32'h2);
    n_chk++;
    if (bus.irq !== 1'b1) begin
      n_err++; $display("FAIL irq_wrong_clear: got %b want 1", bus.irq);
    end
    bus_write(3'd3, 32'h1);
    n_chk++;
    if (bus.irq !== 1'b0) begin
      n_err++; $display("FAIL irq_clear: got %b want 0", bus.irq);
    end
  endtask

  task automatic test_edge_mode();
    bus_write(3'd4, 32'h4);
    bus_write(3'd5, 32'h0);
    bus_write(3'd3, 32'hF);
    bus.address = 3'd3;
    for (int p = 0; p < 3; p++) begin
      in_port[2] = (p == 1);
      repeat (8) begin
        tick(); n_chk++;
        if (bus.readdata !== m_rd || bus.irq !== m_irq()) begin
          n_err++; $display("FAIL edge_b2 p=%0d: rd=%h irq=%b want rd=%h irq=%b", p, bus.readdata, bus.irq, m_rd, m_irq());
        end
      end
    end
    n_chk++;
    if (bus.readdata !== 32'h4) begin
      n_err++; $display("FAIL edge_rise_only: got %h want 00000004", bus.readdata);
    end
    bus_write(3'd3, 32'hF);
    bus.address = 3'd3;
    in_port[3] = 1'b0; repeat (8) tick();
    in_port[3] = 1'b1; repeat (8) tick();
    n_chk++;
    if (bus.readdata !== 32'h0) begin
      n_err++; $display("FAIL edge_b3: got %h want 00000000", bus.readdata);
    end
  endtask

  task automatic test_simul_clear();
    bit hit = 1'b0;
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'hF);
    in_port[0] = 1'b1; repeat (10) tick();
    bus_write(3'd3, 32'hF);
    in_port[0] = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (~m_stable[0] & m_stable_d[0] & m_fall[0]) hit = 1'b1;
      else tick();
    end
    n_chk++;
    if (!hit) begin
      n_err++; $display("FAIL simul_timeout: event never pending, got 0 want 1");
    end else begin
      bus_write(3'd3, 32'h1);
      bus.address = 3'd3; tick(); n_chk++;
      if (bus.readdata[0] !== 1'b1 || bus.readdata !== m_rd) begin
        n_err++; $display("FAIL simul_clear: got %h want bit0=1 (model %h)", bus.readdata, m_rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    in_port[1] = 1'b0; repeat (10) tick();
    bus_write(3'd2, 32'h2);
    bus_write(3'd3, 32'hF);
    in_port[1] = 1'b1;
    repeat (5) tick();
    reset_n = 1'b0;
    @(negedge clk); n_chk++;
    if (bus.readdata !== 32'h0 || bus.irq !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: rd=%h irq=%b want 00000000 0", bus.readdata, bus.irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.address = 3'd0;
    for (int c = 1; c <= 10; c++) begin
      tick(); n_chk++;
      if (bus.readdata !== m_rd || bus.irq !== m_irq() || (c == 6 && bus.readdata[1] !== 1'b0) || (c == 7 && bus.readdata[1] !== 1'b1)) begin
        n_err++; $display("FAIL mid_release c=%0d: rd=%h irq=%b want rd=%h irq=%b", c, bus.readdata, bus.irq, m_rd, m_irq());
      end
    end
    bus.address = 3'd3; tick(); n_chk++;
    if (bus.readdata !== 32'h0 || bus.irq !== 1'b0) begin
      n_err++; $display("FAIL mid_no_capture: rd=%h irq=%b want 00000000 0", bus.readdata, bus.irq);
    end
  endtask

  task automatic test_random();
    bus_write(3'd2, 32'hF);
    for (int c = 0; c < 800; c++) begin
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
      if ($urandom_range(3) == 0) in_port[$urandom_range(3)] ^= 1'b1;
      bus.address = 3'($urandom_range(7));
      if ($urandom_range(5) == 0) begin
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = $urandom;
      end
      tick(); n_chk++;
      if (bus.readdata !== m_rd || bus.irq !== m_irq()) begin
        n_err++; $display("FAIL random c=%0d: rd=%h irq=%b want rd=%h irq=%b", c, bus.readdata, bus.irq, m_rd, m_irq());
      end
    end
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_irq();
    test_edge_mode();
    test_simul_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
